// File: rtl/operand_stage_pkg.sv
// rtl/operand_stage_pkg.sv - shared opcode/funct/regimm encodings, buffer states and op classification
//
// Purpose: single home for the MIPS-style instruction encodings used by the
// operand stage, the output-buffer state encoding, and a helper that maps an
// instruction to which operands it consumes and how its immediate is formed.
// Ports: none (package).

package operand_stage_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LWL     = 6'h22;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_LWR     = 6'h26;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SWL     = 6'h2A;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_SWR     = 6'h2E;

    // SPECIAL funct codes
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;

    // REGIMM selectors (rt field)
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    // Output buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } buf_state_e;

    // How operand_2 is built from the immediate
    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_ZERO = 2'd1,
        IMM_SIGN = 2'd2,
        IMM_HIGH = 2'd3
    } imm_kind_e;

    typedef struct packed {
        logic      rs_used;   // operand_1 takes the rs value
        logic      rt_used;   // operand_2 takes the rt value
        logic      link;      // operand_1 takes the link address
        imm_kind_e imm_kind;  // operand_2 immediate form
    } op_class_t;

    function automatic logic is_load_store(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: is_load_store = 1'b1;
            default:                             is_load_store = 1'b0;
        endcase
    endfunction

    function automatic op_class_t classify(input logic [5:0] op,
                                           input logic [4:0] rt,
                                           input logic [5:0] funct);
        op_class_t c;
        c = '{rs_used: 1'b0, rt_used: 1'b0, link: 1'b0, imm_kind: IMM_NONE};
        case (op)
            OP_SPECIAL: begin
                // JALR still forwards rt into operand_2; only operand_1 changes
                c.rt_used = 1'b1;
                if (funct == FUNCT_JALR) c.link    = 1'b1;
                else                     c.rs_used = 1'b1;
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZAL || rt == RT_BGEZAL) c.link = 1'b1;
            end
            OP_JAL: c.link = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                c.rs_used  = 1'b1;
                c.imm_kind = IMM_SIGN;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                c.rs_used  = 1'b1;
                c.imm_kind = IMM_ZERO;
            end
            OP_LUI: begin
                c.rs_used  = 1'b1;
                c.imm_kind = IMM_HIGH;
            end
            default: begin
                if (is_load_store(op)) begin
                    c.rs_used  = 1'b1;
                    c.imm_kind = IMM_SIGN;
                end
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - forwarding resolution for one source register
//
// Purpose: pick the value of one source register from the forwarding ports
// (lowest index wins) or fall back to the register-file read data. Register 0
// never matches a port.
// Ports:
//   reg_addr_i    source register number
//   reg_data_i    register-file read data
//   fwd_valid_i   per-port write valid
//   fwd_pending_i per-port data-not-yet-available flag
//   fwd_addr_i    per-port destination register, 5 bits each
//   fwd_data_i    per-port forwarded data, DATA_W bits each
//   data_o        resolved value
//   pending_o     resolved port has its data still pending

module operand_fwd_mux #(
    parameter int FWD_N  = 2,
    parameter int DATA_W = 32
) (
    input  logic [4:0]            reg_addr_i,
    input  logic [DATA_W-1:0]     reg_data_i,
    input  logic [FWD_N-1:0]      fwd_valid_i,
    input  logic [FWD_N-1:0]      fwd_pending_i,
    input  logic [5*FWD_N-1:0]    fwd_addr_i,
    input  logic [DATA_W*FWD_N-1:0] fwd_data_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  pending_o
);

    logic hit;

    always_comb begin
        data_o    = reg_data_i;
        pending_o = 1'b0;
        hit       = 1'b0;
        for (int i = 0; i < FWD_N; i++) begin
            if (!hit && reg_addr_i != 5'd0 && fwd_valid_i[i] &&
                fwd_addr_i[5*i +: 5] == reg_addr_i) begin
                hit       = 1'b1;
                data_o    = fwd_data_i[DATA_W*i +: DATA_W];
                pending_o = fwd_pending_i[i];
            end
        end
    end

endmodule

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - operand generation with forwarding, hazard stall and skid buffering
//
// Purpose: compute operand_1/operand_2 for a decoded instruction at acceptance,
// resolving rs/rt through the forwarding ports, stalling while a used operand
// is pending, and presenting results through a main + skid output buffer.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop everything held and offered
//   in_valid/in_ready input handshake
//   addr, op, rt, funct, imm, rs_addr, rt_addr, reg_data_1/2  decoded instruction
//   fwd_valid/fwd_pending/fwd_addr/fwd_data  forwarding ports
//   out_valid/out_ready output handshake
//   operand_1/2, out_addr  held operands and PC
//   stall_cnt         saturating hazard-stall cycle count

module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int IMM_W    = 16,
    parameter int FWD_N    = 2,
    parameter int LINK_OFF = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [5:0]               op,
    input  logic [4:0]               rt,
    input  logic [5:0]               funct,
    input  logic [IMM_W-1:0]         imm,
    input  logic [4:0]               rs_addr,
    input  logic [4:0]               rt_addr,
    input  logic [DATA_W-1:0]        reg_data_1,
    input  logic [DATA_W-1:0]        reg_data_2,
    input  logic [FWD_N-1:0]         fwd_valid,
    input  logic [FWD_N-1:0]         fwd_pending,
    input  logic [5*FWD_N-1:0]       fwd_addr,
    input  logic [DATA_W*FWD_N-1:0]  fwd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        operand_1,
    output logic [DATA_W-1:0]        operand_2,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [15:0]              stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    buf_state_e state_q, state_d;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic [15:0] stall_q, stall_d;

    op_class_t         cls;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              rs_pend, rt_pend;
    logic              hazard;
    logic              accept;
    logic              handshake;
    entry_t            new_entry;

    // Forward resolution
    operand_fwd_mux #(.FWD_N(FWD_N), .DATA_W(DATA_W)) u_fwd_rs (
        .reg_addr_i    (rs_addr),
        .reg_data_i    (reg_data_1),
        .fwd_valid_i   (fwd_valid),
        .fwd_pending_i (fwd_pending),
        .fwd_addr_i    (fwd_addr),
        .fwd_data_i    (fwd_data),
        .data_o        (rs_val),
        .pending_o     (rs_pend)
    );

    operand_fwd_mux #(.FWD_N(FWD_N), .DATA_W(DATA_W)) u_fwd_rt (
        .reg_addr_i    (rt_addr),
        .reg_data_i    (reg_data_2),
        .fwd_valid_i   (fwd_valid),
        .fwd_pending_i (fwd_pending),
        .fwd_addr_i    (fwd_addr),
        .fwd_data_i    (fwd_data),
        .data_o        (rt_val),
        .pending_o     (rt_pend)
    );

    // Operand generation for the offered instruction
    always_comb begin
        cls = classify(op, rt, funct);

        new_entry.pc = addr;

        if (cls.rs_used)   new_entry.op1 = rs_val;
        else if (cls.link) new_entry.op1 = DATA_W'(addr) + DATA_W'(LINK_OFF);
        else               new_entry.op1 = '0;

        if (cls.rt_used) begin
            new_entry.op2 = rt_val;
        end else begin
            case (cls.imm_kind)
                IMM_ZERO: new_entry.op2 = DATA_W'(imm);
                IMM_SIGN: new_entry.op2 = DATA_W'($signed(imm));
                IMM_HIGH: new_entry.op2 = DATA_W'(imm) << (DATA_W - IMM_W);
                default:  new_entry.op2 = '0;
            endcase
        end
    end

    // Only operands the op consumes can stall it
    assign hazard    = in_valid && ((cls.rs_used && rs_pend) || (cls.rt_used && rt_pend));
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_FULL;
                ST_FULL: begin
                    if (accept && !out_ready)      state_d = ST_SKID;
                    else if (!accept && out_ready) state_d = ST_EMPTY;
                end
                ST_SKID: if (out_ready) state_d = ST_FULL;
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Output logic
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = !rst && (state_q != ST_SKID) && !hazard;
    end

    // Buffer contents follow the same transitions as the state machine
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: if (accept) main_d = new_entry;
                ST_FULL: begin
                    if (accept && out_ready) main_d = new_entry;
                    else if (accept)         skid_d = new_entry;
                end
                ST_SKID: if (out_ready) main_d = skid_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (hazard && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign operand_1 = main_q.op1;
    assign operand_2 = main_q.op2;
    assign out_addr  = main_q.pc;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - directed self-checking bench for operand_stage

module tb_operand_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] addr;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] reg_data_1;
    logic [31:0] reg_data_2;
    logic [1:0]  fwd_valid;
    logic [1:0]  fwd_pending;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic [31:0] out_addr;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    operand_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .addr        (addr),
        .op          (op),
        .rt          (rt),
        .funct       (funct),
        .imm         (imm),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .reg_data_1  (reg_data_1),
        .reg_data_2  (reg_data_2),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .operand_1   (operand_1),
        .operand_2   (operand_2),
        .out_addr    (out_addr),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0; addr = 0; op = 0; rt = 0; funct = 0; imm = 0;
        rs_addr = 0; rt_addr = 0; reg_data_1 = 0; reg_data_2 = 0;
        fwd_valid = 0; fwd_pending = 0; fwd_addr = 0; fwd_data = 0;
    endtask

    // Leaves two ORI entries held (A: 0x100 @0xA0, B: 0x200 @0xB0)
    task automatic fill_skid();
        clear_inputs();
        out_ready = 0;
        op = 6'h0D; rs_addr = 5'd1; in_valid = 1;
        reg_data_1 = 32'h100; imm = 16'h1; addr = 32'hA0;
        tick();
        reg_data_1 = 32'h200; imm = 16'h2; addr = 32'hB0;
        tick();
        in_valid = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        out_ready = 1;
        rst = 1;
        tick();
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if ({operand_1, operand_2, out_addr} !== 96'h0) begin n_err++; $display("FAIL reset_outputs: got %h %h %h expected 0", operand_1, operand_2, out_addr); end
        n_cmp++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); end
        rst = 0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_ori();
        clear_inputs();
        out_ready = 1;
        op = 6'h0D; rs_addr = 5'd3; reg_data_1 = 32'h1234; imm = 16'h8001; addr = 32'h100;
        in_valid = 1;
        tick();
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ori_valid: got %b expected 1", out_valid); end
        n_cmp++; if (operand_1 !== 32'h1234) begin n_err++; $display("FAIL ori_op1: got %h expected 00001234", operand_1); end
        n_cmp++; if (operand_2 !== 32'h00008001) begin n_err++; $display("FAIL ori_op2: got %h expected 00008001", operand_2); end
        n_cmp++; if (out_addr !== 32'h100) begin n_err++; $display("FAIL ori_addr: got %h expected 00000100", out_addr); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ori_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        out_ready = 1;
        op = 6'h09; rs_addr = 5'd5; reg_data_1 = 32'h5555; imm = 16'h8000;
        fwd_valid = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'hBBBB, 32'hAAAA};
        in_valid = 1;
        tick();
        in_valid = 0;
        n_cmp++; if (operand_1 !== 32'hAAAA) begin n_err++; $display("FAIL fwd_prio_op1: got %h expected 0000aaaa", operand_1); end
        n_cmp++; if (operand_2 !== 32'hFFFF8000) begin n_err++; $display("FAIL fwd_prio_op2: got %h expected ffff8000", operand_2); end
        tick();
    endtask

    task automatic test_hazard();
        clear_inputs();
        out_ready = 1;
        op = 6'h00; funct = 6'h21; rs_addr = 5'd2; rt_addr = 5'd7;
        reg_data_1 = 32'h11; reg_data_2 = 32'h22;
        fwd_valid = 2'b10; fwd_pending = 2'b10; fwd_addr = {5'd7, 5'd0}; fwd_data = {32'h77, 32'h0};
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hazard_in_ready_%0d: got %b expected 0", i, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hazard_no_capture_%0d: got %b expected 0", i, out_valid); end
        end
        n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL hazard_stall_cnt: got %0d expected 3", stall_cnt); end
        fwd_pending = 2'b00; fwd_data = {32'h7777, 32'h0};
        out_ready = 0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hazard_release: got %b expected 1", in_ready); end
        tick();
        in_valid = 0;
        n_cmp++; if (operand_2 !== 32'h7777) begin n_err++; $display("FAIL hazard_op2: got %h expected 00007777", operand_2); end
        n_cmp++; if (operand_1 !== 32'h11) begin n_err++; $display("FAIL hazard_op1: got %h expected 00000011", operand_1); end
        n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL hazard_stall_hold: got %0d expected 3", stall_cnt); end
        // Held operands must not follow later forwarding activity
        fwd_data = {32'hDEAD, 32'h0};
        tick();
        n_cmp++; if (operand_2 !== 32'h7777) begin n_err++; $display("FAIL hazard_frozen: got %h expected 00007777", operand_2); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_unused_and_zero();
        // BEQ consumes no operand: a pending match on rs must not stall
        clear_inputs();
        out_ready = 1;
        op = 6'h04; rs_addr = 5'd4; reg_data_1 = 32'h44; imm = 16'h10;
        fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_addr = {5'd0, 5'd4};
        in_valid = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL unused_no_stall: got %b expected 1", in_ready); end
        tick();
        n_cmp++; if ({operand_1, operand_2} !== 64'h0) begin n_err++; $display("FAIL beq_zero_ops: got %h %h expected 0 0", operand_1, operand_2); end
        // Register 0 is never forwarded nor stalled on
        op = 6'h09; rs_addr = 5'd0; reg_data_1 = 32'h99; imm = 16'h0004;
        fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_addr = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hCAFE};
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL r0_no_stall: got %b expected 1", in_ready); end
        tick();
        in_valid = 0;
        n_cmp++; if (operand_1 !== 32'h99) begin n_err++; $display("FAIL r0_reg_data: got %h expected 00000099", operand_1); end
        n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL r0_stall_cnt: got %0d expected 3", stall_cnt); end
        tick();
    endtask

    task automatic test_jal();
        clear_inputs();
        out_ready = 1;
        op = 6'h03; addr = 32'h00400010; imm = 16'h1234;
        in_valid = 1;
        tick();
        in_valid = 0;
        n_cmp++; if (operand_1 !== 32'h00400018) begin n_err++; $display("FAIL jal_op1: got %h expected 00400018", operand_1); end
        n_cmp++; if (operand_2 !== 32'h0) begin n_err++; $display("FAIL jal_op2: got %h expected 00000000", operand_2); end
        // LUI places imm in the upper half
        op = 6'h0F; imm = 16'hABCD; rs_addr = 5'd0; reg_data_1 = 32'h0;
        in_valid = 1;
        tick();
        in_valid = 0;
        n_cmp++; if (operand_2 !== 32'hABCD0000) begin n_err++; $display("FAIL lui_op2: got %h expected abcd0000", operand_2); end
        tick();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        out_ready = 0;
        op = 6'h0D; rs_addr = 5'd1; in_valid = 1;
        reg_data_1 = 32'h100; imm = 16'h1; addr = 32'hA0;
        tick();
        reg_data_1 = 32'h200; imm = 16'h2; addr = 32'hB0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_second_ready: got %b expected 1", in_ready); end
        tick();
        reg_data_1 = 32'h300; imm = 16'h3; addr = 32'hC0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_third_blocked: got %b expected 0", in_ready); end
        n_cmp++; if (operand_1 !== 32'h100 || out_addr !== 32'hA0) begin n_err++; $display("FAIL b2b_first_held: got %h @%h expected 00000100 @000000a0", operand_1, out_addr); end
        tick();
        n_cmp++; if (operand_1 !== 32'h100 || operand_2 !== 32'h1 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_stable: got %h %h v=%b expected 00000100 00000001 v=1", operand_1, operand_2, out_valid); end
        in_valid = 0;
        out_ready = 1;
        tick();
        n_cmp++; if (operand_1 !== 32'h200 || operand_2 !== 32'h2 || out_addr !== 32'hB0 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second_out: got %h %h @%h v=%b expected 00000200 00000002 @000000b0 v=1", operand_1, operand_2, out_addr, out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush_skid();
        fill_skid();
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_pre_skid: got %b expected 0", in_ready); end
        flush = 1; in_valid = 1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        flush = 0; in_valid = 0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped_input: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_skid();
        fill_skid();
        rst = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_skid_in_ready: got %b expected 0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_skid_valid: got %b expected 0", out_valid); end
        n_cmp++; if ({operand_1, operand_2, out_addr} !== 96'h0) begin n_err++; $display("FAIL rst_skid_outputs: got %h %h %h expected 0", operand_1, operand_2, out_addr); end
        n_cmp++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL rst_skid_stall_cnt: got %0d expected 0", stall_cnt); end
        rst = 0;
        out_ready = 1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_skid_no_residue: got %b expected 0", out_valid); end
    endtask

    initial begin
        rst = 1;
        out_ready = 1;
        clear_inputs();
        test_reset();
        test_ori();
        test_fwd_priority();
        test_hazard();
        test_unused_and_zero();
        test_jal();
        test_back_to_back();
        test_flush_skid();
        test_reset_skid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
